// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA raster timing generator.
//   - Default 640x480 @ 60 Hz timing values (pixels for horizontal, lines for
//     vertical) and the totals derived from them.
//   - Coordinate width for DrawX/DrawY and the frame counter width.
// Optional feature used by vga_timing_gen: VGA_SYNC_DELAY_EN.
// -----------------------------------------------------------------------------
package vga_pkg;

    // Horizontal timing defaults, in pixel clocks
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;

    // Vertical timing defaults, in lines
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Both raster coordinates fit in 10 bits (max 799)
    localparam int COORD_W = 10;

    // Frame counter width; wraps silently
    localparam int FRAME_COUNT_W = 16;

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: a wrapping counter plus registered region flags.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   en       in   advance the counter this cycle
//   count    out  current position, 0..TOTAL-1 (resets to TOTAL-1)
//   wrap     out  count is at TOTAL-1 (next enabled advance wraps to 0)
//   active   out  registered: count < ACTIVE
//   in_sync  out  registered: SYNC_START <= count < SYNC_END
// The region flags are computed from the next count value, so they line up
// with the count they describe instead of trailing it by a cycle.
// -----------------------------------------------------------------------------
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int W          = COORD_W,
    parameter int TOTAL      = H_TOTAL_DEF,
    parameter int ACTIVE     = H_VISIBLE_DEF,
    parameter int SYNC_START = H_VISIBLE_DEF + H_FP_DEF,
    parameter int SYNC_END   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         in_sync
);

    localparam logic [W-1:0] LAST      = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END   = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_LO   = W'(SYNC_START);
    localparam logic [W-1:0] SYNC_HI   = W'(SYNC_END);

    logic [W-1:0] count_next;

    // Work out where the counter lands on the next edge. Holding when not
    // enabled lets the vertical axis step only on horizontal wrap.
    always_comb begin
        wrap       = (count == LAST);
        count_next = count;
        if (en) begin
            count_next = wrap ? '0 : count + W'(1);
        end
    end

    // Counter and region flags. Reset parks the counter on its last value so
    // the first edge after reset lands exactly on position 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= LAST;
            active  <= 1'b0;
            in_sync <= 1'b0;
        end else begin
            count   <= count_next;
            active  <= (count_next < ACT_END);
            in_sync <= (count_next >= SYNC_LO) && (count_next < SYNC_HI);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// 640x480 @ 60 Hz VGA raster timing from the 25 MHz pixel clock.
// Ports:
//   vga_clk       in   pixel clock
//   reset_n       in   asynchronous active-low reset
//   DrawX         out  horizontal position 0..H_TOTAL-1
//   DrawY         out  vertical position 0..V_TOTAL-1
//   blank         out  1 inside the visible 640x480 region
//   hs, vs        out  active-low sync pulses
//   sync          out  composite sync, tied 0
//   line_start    out  pulse at DrawX==0
//   frame_start   out  pulse at DrawX==0, DrawY==0
//   vblank_start  out  pulse at DrawX==0, DrawY==V_VISIBLE
//   frame_count   out  number of frame_start pulses since reset
// Optional feature: define VGA_SYNC_DELAY_EN to delay hs/vs by one clock so
// they line up with renderer RGB that is registered one clock after DrawX.
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF
) (
    input  logic                     vga_clk,
    input  logic                     reset_n,
    output logic [COORD_W-1:0]       DrawX,
    output logic [COORD_W-1:0]       DrawY,
    output logic                     blank,
    output logic                     hs,
    output logic                     vs,
    output logic                     sync,
    output logic                     line_start,
    output logic                     frame_start,
    output logic                     vblank_start,
    output logic [FRAME_COUNT_W-1:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Last visible line: wrapping off its end starts vertical blanking
    localparam logic [COORD_W-1:0] LAST_VIS_LINE = COORD_W'(V_VISIBLE - 1);

    logic h_wrap, h_active, h_in_sync;
    logic v_wrap, v_active, v_in_sync;
    logic hs_core, vs_core;

    // Horizontal axis runs every clock
    vga_axis_counter #(
        .W          (COORD_W),
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_VISIBLE),
        .SYNC_START (H_VISIBLE + H_FP),
        .SYNC_END   (H_VISIBLE + H_FP + H_SYNC)
    ) u_h_axis (
        .clk     (vga_clk),
        .rst_n   (reset_n),
        .en      (1'b1),
        .count   (DrawX),
        .wrap    (h_wrap),
        .active  (h_active),
        .in_sync (h_in_sync)
    );

    // Vertical axis steps on the same edge the horizontal axis wraps
    vga_axis_counter #(
        .W          (COORD_W),
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_VISIBLE),
        .SYNC_START (V_VISIBLE + V_FP),
        .SYNC_END   (V_VISIBLE + V_FP + V_SYNC)
    ) u_v_axis (
        .clk     (vga_clk),
        .rst_n   (reset_n),
        .en      (h_wrap),
        .count   (DrawY),
        .wrap    (v_wrap),
        .active  (v_active),
        .in_sync (v_in_sync)
    );

    // Region flags are already registered against the new coordinates
    assign blank   = h_active & v_active;
    assign hs_core = ~h_in_sync;
    assign vs_core = ~v_in_sync;
    assign sync    = 1'b0;

`ifdef VGA_SYNC_DELAY_EN
    logic hs_dly, vs_dly;

    // Extra stage so sync edges match the renderer's registered RGB. Reset to
    // the inactive (high) level so nothing pulses while in reset.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_dly <= 1'b1;
            vs_dly <= 1'b1;
        end else begin
            hs_dly <= hs_core;
            vs_dly <= vs_core;
        end
    end

    assign hs = hs_dly;
    assign vs = vs_dly;
`else
    assign hs = hs_core;
    assign vs = vs_core;
`endif

    // Strobes are decoded from the current position one edge early, so each
    // pulse is high in the same cycle as the coordinate it marks. Because the
    // counters reset to their last values, the first edge out of reset sees
    // both wraps and raises frame_start.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            frame_count  <= '0;
        end else begin
            line_start   <= h_wrap;
            frame_start  <= h_wrap & v_wrap;
            vblank_start <= h_wrap & (DrawY == LAST_VIS_LINE);
            if (h_wrap && v_wrap) begin
                frame_count <= frame_count + FRAME_COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench for vga_timing_gen. Horizontal timing uses the real 640x480
// values; the vertical axis is shrunk (6 visible, 2 FP, 2 sync, 3 BP = 13
// lines) so whole frames fit in a short run.
// Honors VGA_SYNC_DELAY_EN when computing expected hs/vs positions.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int VV = 6;
    localparam int VT = 13;
`ifdef VGA_SYNC_DELAY_EN
    localparam int SD = 1;
`else
    localparam int SD = 0;
`endif

    logic        vga_clk;
    logic        reset_n;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        sync;
    logic        line_start;
    logic        frame_start;
    logic        vblank_start;
    logic [15:0] frame_count;

    int total;
    int bad;

    vga_timing_gen #(
        .V_VISIBLE (6),
        .V_FP      (2),
        .V_SYNC    (2),
        .V_BP      (3)
    ) dut (
        .vga_clk      (vga_clk),
        .reset_n      (reset_n),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .blank        (blank),
        .hs           (hs),
        .vs           (vs),
        .sync         (sync),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .vblank_start (vblank_start),
        .frame_count  (frame_count)
    );

    // 25 MHz pixel clock
    initial vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    // One comparison: counts it, and reports tag/observed/expected on failure
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge vga_clk);
            #1;
        end
    endtask

    // Directed sequence: reset, mid-line reset, one line scan, line wrap into
    // vertical blanking, vsync window, frame wrap.
    initial begin
        int hs_low, hs_first, hs_last, bl_cnt, bl_last, ls_cnt, x_err;
        int vs_low, vs_first_x, vs_first_y, extra_pulse;
        bit reached;

        total   = 0;
        bad     = 0;
        reset_n = 1'b1;

        #5 reset_n = 1'b0;
        #10;
        checkOutput("rst_x", 32'(DrawX), 799);
        checkOutput("rst_y", 32'(DrawY), VT - 1);
        checkOutput("rst_blank", 32'(blank), 0);
        checkOutput("rst_hs", 32'(hs), 1);
        checkOutput("rst_vs", 32'(vs), 1);
        checkOutput("rst_sync", 32'(sync), 0);
        checkOutput("rst_strobes", 32'({line_start, frame_start, vblank_start}), 0);
        checkOutput("rst_fc", 32'(frame_count), 0);

        @(negedge vga_clk);
        reset_n = 1'b1;
        applyStimulus(1);
        checkOutput("first_x", 32'(DrawX), 0);
        checkOutput("first_y", 32'(DrawY), 0);
        checkOutput("first_blank", 32'(blank), 1);
        checkOutput("first_ls", 32'(line_start), 1);
        checkOutput("first_fs", 32'(frame_start), 1);
        checkOutput("first_fc", 32'(frame_count), 1);

        applyStimulus(300);
        checkOutput("x300", 32'(DrawX), 300);
        checkOutput("x300_ls", 32'(line_start), 0);
        reset_n = 1'b0;
        #2;
        checkOutput("mid_rst_x", 32'(DrawX), 799);
        checkOutput("mid_rst_y", 32'(DrawY), VT - 1);
        checkOutput("mid_rst_blank", 32'(blank), 0);
        checkOutput("mid_rst_hsvs", 32'({hs, vs}), 3);
        checkOutput("mid_rst_fc", 32'(frame_count), 0);
        @(negedge vga_clk);
        reset_n = 1'b1;
        applyStimulus(1);
        checkOutput("rel_xy", 32'({DrawX, DrawY}), 0);
        checkOutput("rel_fs", 32'(frame_start), 1);
        checkOutput("rel_fc", 32'(frame_count), 1);

        // Scan line 0 cycle by cycle
        hs_low = 0; hs_first = -1; hs_last = -1;
        bl_cnt = 0; bl_last = -1; ls_cnt = 0; x_err = 0;
        for (int i = 0; i < 800; i++) begin
            if (DrawX != 10'(i)) x_err++;
            if (!hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = i;
                hs_last = i;
            end
            if (blank) begin
                bl_cnt++;
                bl_last = i;
            end
            if (line_start) ls_cnt++;
            applyStimulus(1);
        end
        checkOutput("line_x_seq_errs", 32'(x_err), 0);
        checkOutput("hs_low_cycles", 32'(hs_low), 96);
        checkOutput("hs_first_x", 32'(hs_first), 656 + SD);
        checkOutput("hs_last_x", 32'(hs_last), 751 + SD);
        checkOutput("blank_cycles", 32'(bl_cnt), 640);
        checkOutput("blank_last_x", 32'(bl_last), 639);
        checkOutput("line_start_cnt", 32'(ls_cnt), 1);
        checkOutput("line1_y", 32'(DrawY), 1);
        checkOutput("line1_blank", 32'(blank), 1);
        checkOutput("line1_ls", 32'(line_start), 1);

        // Line wrap 5 -> 6, which is also the first blanked line
        applyStimulus(4 * 800 + 799);
        checkOutput("pre_wrap_x", 32'(DrawX), 799);
        checkOutput("pre_wrap_y", 32'(DrawY), 5);
        checkOutput("pre_wrap_blank", 32'(blank), 0);
        applyStimulus(1);
        checkOutput("wrap_x", 32'(DrawX), 0);
        checkOutput("wrap_y", 32'(DrawY), VV);
        checkOutput("wrap_ls", 32'(line_start), 1);
        checkOutput("wrap_vblank", 32'(vblank_start), 1);
        checkOutput("wrap_blank", 32'(blank), 0);
        checkOutput("wrap_fs", 32'(frame_start), 0);
        applyStimulus(1);
        checkOutput("vblank_pulse_end", 32'(vblank_start), 0);

        // Run to the last pixel of the frame, measuring the vsync window
        vs_low = 0; vs_first_x = -1; vs_first_y = -1; extra_pulse = 0;
        reached = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (DrawX == 10'd799 && DrawY == 10'(VT - 1)) begin
                reached = 1'b1;
                break;
            end
            if (!vs) begin
                vs_low++;
                if (vs_first_x < 0) begin
                    vs_first_x = int'(DrawX);
                    vs_first_y = int'(DrawY);
                end
            end
            if (vblank_start || frame_start) extra_pulse++;
            applyStimulus(1);
        end
        checkOutput("frame_end_reached", 32'(reached), 1);
        checkOutput("vs_low_cycles", 32'(vs_low), 1600);
        checkOutput("vs_first_y", 32'(vs_first_y), 8);
        checkOutput("vs_first_x", 32'(vs_first_x), SD);
        checkOutput("no_extra_pulses", 32'(extra_pulse), 0);
        checkOutput("pre_frame_fc", 32'(frame_count), 1);

        applyStimulus(1);
        checkOutput("frame_wrap_xy", 32'({DrawX, DrawY}), 0);
        checkOutput("frame_wrap_fs", 32'(frame_start), 1);
        checkOutput("frame_wrap_fc", 32'(frame_count), 2);
        checkOutput("frame_wrap_blank", 32'(blank), 1);
        applyStimulus(1);
        checkOutput("fs_pulse_end", 32'(frame_start), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
